// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and constants for the PIC10F200 cycle controller
package pic_pkg;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } q_phase_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    SLEEP = 2'd2
  } cyc_mode_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    W    = 2'd1,
    FILE = 2'd2
  } dest_t;

  localparam logic [4:0] INDF_ADDR = 5'h00;
  localparam logic [4:0] FSR_ADDR  = 5'h04;

endpackage

// File: rtl/pic_cycle_ctrl_q_phase_gen.sv
// rtl/pic_cycle_ctrl_q_phase_gen.sv - Q1..Q4 phase counter with hold
module q_phase_gen
  import pic_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     hold,
  output q_phase_t phase
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= Q1;
    end else if (!hold) begin
      phase <= q_phase_t'(phase + 2'd1);
    end
  end

endmodule

// File: rtl/pic_cycle_ctrl.sv
// rtl/pic_cycle_ctrl.sv - instruction-cycle mode FSM, INDF resolution and strobe decode (optional PIC_SLEEP_EN)
module pic_cycle_ctrl
  import pic_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        dec_dest,
  input  logic              dec_status_we,
  input  logic              dec_branch,
  input  logic              dec_skip,
  input  logic              skip_take,
  input  logic              dec_sleep,
  input  logic              wake,
  input  logic [ADDR_W-1:0] file_addr,
  input  logic [ADDR_W-1:0] fsr_bus,
  output logic [1:0]        q_phase,
  output logic [ADDR_W-1:0] eff_addr,
  output logic              indf_null,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              ir_load,
  output logic              w_load,
  output logic              file_we,
  output logic              fsr_load,
  output logic              status_load,
  output logic              flush,
  output logic              sleeping
);

  q_phase_t  phase;
  cyc_mode_t mode, mode_nxt;
  logic      is_indf;
  logic      awake;
  logic      run_q4;

  q_phase_gen u_q_phase_gen (
    .clk   (clk),
    .rst   (rst),
    .hold  (mode == SLEEP),
    .phase (phase)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode <= FLUSH;
    end else begin
      mode <= mode_nxt;
    end
  end

  assign is_indf   = (file_addr == ADDR_W'(INDF_ADDR));
  assign eff_addr  = is_indf ? fsr_bus : file_addr;
  assign indf_null = is_indf && (fsr_bus == '0);

  // rst gates the strobes so nothing leaks out while reset is held
  assign awake  = rst && (mode != SLEEP);
  assign run_q4 = rst && (mode == RUN) && (phase == Q4);

  always_comb begin
    mode_nxt    = mode;
    pc_inc      = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    w_load      = 1'b0;
    file_we     = 1'b0;
    fsr_load    = 1'b0;
    status_load = 1'b0;

    case (mode)
      RUN: begin
        if (phase == Q4) begin
          if (dec_branch || (dec_skip && skip_take)) begin
            mode_nxt = FLUSH;
          end
`ifdef PIC_SLEEP_EN
          else if (dec_sleep) begin
            mode_nxt = SLEEP;
          end
`endif
        end
      end
      FLUSH: begin
        if (phase == Q4) begin
          mode_nxt = RUN;
        end
      end
`ifdef PIC_SLEEP_EN
      SLEEP: begin
        if (wake) begin
          mode_nxt = FLUSH;
        end
      end
`endif
      default: mode_nxt = FLUSH;
    endcase

    pc_inc  = awake && (phase == Q1);
    ir_load = awake && (phase == Q4);

    if (run_q4) begin
      pc_load     = dec_branch;
      status_load = dec_status_we;
      w_load      = (dec_dest == W);
      if (dec_dest == FILE) begin
        if (eff_addr == ADDR_W'(FSR_ADDR)) begin
          fsr_load = 1'b1;
        end else if (!indf_null) begin
          file_we = 1'b1;
        end
      end
    end
  end

  assign q_phase = phase;
  assign flush   = (mode == FLUSH);

`ifdef PIC_SLEEP_EN
  assign sleeping = (mode == SLEEP);
`else
  logic unused_sleep_inputs;
  assign unused_sleep_inputs = wake ^ dec_sleep;
  assign sleeping = 1'b0;
`endif

endmodule

// File: tb/tb_pic_cycle_ctrl.sv
// tb/tb_pic_cycle_ctrl.sv - randomized self-checking bench for pic_cycle_ctrl against a slot-level model
module tb_pic_cycle_ctrl;

  localparam int AW = 5;
`ifdef PIC_SLEEP_EN
  localparam bit SLEEP_EN = 1'b1;
`else
  localparam bit SLEEP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    dec_dest;
  logic          dec_status_we, dec_branch, dec_skip, skip_take, dec_sleep, wake;
  logic [AW-1:0] file_addr, fsr_bus;
  logic [1:0]    q_phase;
  logic [AW-1:0] eff_addr;
  logic          indf_null, pc_inc, pc_load, ir_load, w_load, file_we, fsr_load, status_load;
  logic          flush, sleeping;

  pic_cycle_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .dec_dest(dec_dest), .dec_status_we(dec_status_we),
    .dec_branch(dec_branch), .dec_skip(dec_skip), .skip_take(skip_take),
    .dec_sleep(dec_sleep), .wake(wake), .file_addr(file_addr), .fsr_bus(fsr_bus),
    .q_phase(q_phase), .eff_addr(eff_addr), .indf_null(indf_null),
    .pc_inc(pc_inc), .pc_load(pc_load), .ir_load(ir_load), .w_load(w_load),
    .file_we(file_we), .fsr_load(fsr_load), .status_load(status_load),
    .flush(flush), .sleeping(sleeping)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // slot model: clk index inside the instruction slot, and what kind of slot it is
  int    m_tick;
  string m_slot;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {pc_inc, pc_load, ir_load, w_load, file_we, fsr_load, status_load};
  endfunction

  task automatic check_now();
    int         ea;
    bit         nul, exec, live;
    logic [6:0] exp_s;
    ea    = (file_addr == 0) ? int'(fsr_bus) : int'(file_addr);
    nul   = (file_addr == 0) && (fsr_bus == 0);
    live  = (m_slot != "sleep");
    exec  = (m_slot == "run") && (m_tick == 3);
    exp_s = {live && m_tick == 0,
             exec && dec_branch,
             live && m_tick == 3,
             exec && dec_dest == 2'd1,
             exec && dec_dest == 2'd2 && ea != 4 && !nul,
             exec && dec_dest == 2'd2 && ea == 4,
             exec && dec_status_we};
    check("q_phase", 32'(q_phase), 32'(m_tick));
    check("flush", 32'(flush), 32'(m_slot == "flush"));
    check("sleeping", 32'(sleeping), 32'(m_slot == "sleep"));
    check("eff_addr", 32'(eff_addr), 32'(ea));
    check("indf_null", 32'(indf_null), 32'(nul));
    check("strobes", 32'(strobes()), 32'(exp_s));
  endtask

  task automatic model_edge();
    if (m_slot == "sleep") begin
      if (wake) m_slot = "flush";
    end else begin
      if (m_tick == 3) begin
        if (m_slot == "flush") m_slot = "run";
        else if (dec_branch || (dec_skip && skip_take)) m_slot = "flush";
        else if (SLEEP_EN && dec_sleep) m_slot = "sleep";
      end
      m_tick = (m_tick + 1) % 4;
    end
  endtask

  task automatic tick();
    #4;
    check_now();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic [1:0] d, input logic swe, input logic br, input logic sk,
                        input logic tk, input logic sl, input logic wk,
                        input logic [AW-1:0] fa, input logic [AW-1:0] fsr);
    dec_dest = d; dec_status_we = swe; dec_branch = br; dec_skip = sk;
    skip_take = tk; dec_sleep = sl; wake = wk; file_addr = fa; fsr_bus = fsr;
  endtask

  task automatic slot(input logic [1:0] d, input logic swe, input logic br, input logic sk,
                      input logic tk, input logic sl, input logic [AW-1:0] fa, input logic [AW-1:0] fsr);
    set_in(d, swe, br, sk, tk, sl, 1'b0, fa, fsr);
    repeat (4) tick();
  endtask

  // enters at posedge+1, asserts reset mid-phase, leaves at posedge+1 after release
  task automatic mid_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_strobes", 32'(strobes()), 32'd0);
    check("rst_q_phase", 32'(q_phase), 32'd0);
    check("rst_flush", 32'(flush), 32'd1);
    check("rst_sleeping", 32'(sleeping), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    m_tick = 0;
    m_slot = "flush";
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return AW'(4);
      default: return AW'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    set_in(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AW'(5), AW'(0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_strobes", 32'(strobes()), 32'd0);
    check("reset_q_phase", 32'(q_phase), 32'd0);
    check("reset_flush", 32'(flush), 32'd1);
    check("reset_sleeping", 32'(sleeping), 32'd0);
    rst    = 1'b1;
    m_tick = 0;
    m_slot = "flush";

    repeat (4) tick();
    slot(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, AW'(4),    AW'(0));
    slot(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AW'(5'h10), AW'(0));
    slot(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AW'(0),    AW'(5'h12));
    slot(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, AW'(0),    AW'(0));
    slot(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, AW'(3),    AW'(0));
    slot(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AW'(3),    AW'(0));
    slot(2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, AW'(5'h10), AW'(0));
    slot(2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, AW'(5'h10), AW'(0));
    slot(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AW'(7),    AW'(0));
    slot(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, AW'(7),    AW'(0));
    slot(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, AW'(7),    AW'(0));

`ifdef PIC_SLEEP_EN
    slot(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, AW'(7), AW'(0));
    repeat (20) tick();
    wake = 1'b1;
    tick();
    wake = 1'b0;
    dec_sleep = 1'b0;
    dec_dest = 2'd1;
    repeat (8) tick();
    slot(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, AW'(7), AW'(0));
    repeat (3) tick();
    check("sleep_before_reset", 32'(sleeping), 32'd1);
    mid_reset();
    dec_sleep = 1'b0;
    repeat (8) tick();
`endif

    for (int i = 0; i < 3000; i++) begin
      if (m_tick == 0) begin
        dec_dest      = 2'($urandom_range(0, 3));
        dec_status_we = 1'($urandom);
        dec_branch    = ($urandom_range(0, 7) == 0);
        dec_skip      = ($urandom_range(0, 3) == 0);
        dec_sleep     = !dec_branch && ($urandom_range(0, 15) == 0);
        file_addr     = pick_addr();
        fsr_bus       = pick_addr();
      end
      skip_take = 1'($urandom);
      wake      = ($urandom_range(0, 7) == 0);
      if (i % 400 == 399) mid_reset();
      else tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
